fft_agu: RTL and testbench

//  Address-generation/sequencing unit for in-place radix-2 DIT FFT; sits directly upstream of bfu.
//  Per butterfly: sample-RAM read addresses (a, b) and twiddle-ROM address, whose data feed bfu a/b/tw.

---
 rtl/fft_agu.sv | 205 ++++++++++++++++++++
 tb/tb_fft_agu.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/fft_agu.sv
// Address generator and sequencer for an in-place radix-2 DIT FFT.
// Issues butterfly read/twiddle addresses stage by stage and delays them for in-place writeback.
module fft_agu #(
  parameter int N_LOG2    = 3,
  parameter int FLUSH_CYC = 3,
  parameter int WB_LAT    = 3
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              hold,
  output logic              busy,
  output logic              done,
  output logic              issue_valid,
  output logic [N_LOG2-1:0] addr_a,
  output logic [N_LOG2-1:0] addr_b,
  output logic [N_LOG2-2:0] tw_addr,
  output logic [3:0]        stage,
  output logic              wb_valid,
  output logic [N_LOG2-1:0] wb_addr_a,
  output logic [N_LOG2-1:0] wb_addr_b
);

  localparam int              KW     = N_LOG2 - 1;
  localparam int              DW     = 1 + 2 * N_LOG2;
  localparam logic [KW-1:0]   K_LAST = '1;
  localparam logic [KW-1:0]   K_ONE  = KW'(1);
  localparam logic [N_LOG2-1:0] A_ONE = N_LOG2'(1);
  localparam logic [3:0]      S_LAST = 4'(N_LOG2 - 1);
  localparam logic [3:0]      F_LAST = 4'(FLUSH_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RUN   = 3'd1,
    S_FLUSH = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [KW-1:0]       k_q, k_d;
  logic [3:0]          stg_q, stg_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                iv_q, iv_d;
  logic [N_LOG2-1:0]   a_q, a_d;
  logic [N_LOG2-1:0]   b_q, b_d;
  logic [KW-1:0]       tw_q, tw_d;
  logic [3:0]          stage_q, stage_d;
  logic [DW-1:0]       dly_q [WB_LAT];
  logic [DW-1:0]       dly_d [WB_LAT];

  logic [N_LOG2-1:0]   kx_s, span_s, pos_s, grp_s, a_s, b_s;
  logic [KW-1:0]       tw_s;

  // Butterfly address math for the current (stage, k)
  always_comb begin
    kx_s   = {1'b0, k_q};
    span_s = A_ONE << stg_q;
    pos_s  = kx_s & (span_s - A_ONE);
    grp_s  = kx_s >> stg_q;
    a_s    = (grp_s << (stg_q + 4'd1)) | pos_s;
    b_s    = a_s + span_s;
    tw_s   = pos_s[KW-1:0] << (S_LAST - stg_q);
  end

  // Sequencer next-state and registered-output computation
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    stg_d   = stg_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    iv_d    = 1'b0;
    a_d     = a_q;
    b_d     = b_q;
    tw_d    = tw_q;
    stage_d = stage_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          k_d     = '0;
          stg_d   = 4'd0;
          cnt_d   = 4'd0;
          busy_d  = 1'b1;
          stage_d = 4'd0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        if (hold) begin
          iv_d = 1'b0;
        end else begin
          iv_d    = 1'b1;
          a_d     = a_s;
          b_d     = b_s;
          tw_d    = tw_s;
          stage_d = stg_q;
          // k stays at its last value through the bubbles; it wraps at the stage change
          if (k_q == K_LAST) begin
            cnt_d   = 4'd0;
            state_d = (stg_q == S_LAST) ? S_DRAIN : S_FLUSH;
          end else begin
            k_d = k_q + K_ONE;
          end
        end
      end
      S_FLUSH: begin
        if (cnt_q == F_LAST) begin
          state_d = S_RUN;
          stg_d   = stg_q + 4'd1;
          k_d     = '0;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_DRAIN: begin
        if (cnt_q == F_LAST) begin
          state_d = S_DONE;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
        stg_d   = 4'd0;
        k_d     = '0;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // Writeback delay line shifts every cycle; the bfu pipeline has no stall
  always_comb begin
    dly_d[0] = {iv_q, a_q, b_q};
    for (int i = 1; i < WB_LAT; i++) begin
      dly_d[i] = dly_q[i-1];
    end
  end

  // State, counter and output registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      stg_q   <= 4'd0;
      cnt_q   <= 4'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      iv_q    <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      tw_q    <= '0;
      stage_q <= 4'd0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      stg_q   <= stg_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      iv_q    <= iv_d;
      a_q     <= a_d;
      b_q     <= b_d;
      tw_q    <= tw_d;
      stage_q <= stage_d;
    end
  end

  // Delay line registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < WB_LAT; i++) begin
        dly_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < WB_LAT; i++) begin
        dly_q[i] <= dly_d[i];
      end
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign issue_valid = iv_q;
  assign addr_a      = a_q;
  assign addr_b      = b_q;
  assign tw_addr     = tw_q;
  assign stage       = stage_q;
  assign wb_valid    = dly_q[WB_LAT-1][DW-1];
  assign wb_addr_a   = dly_q[WB_LAT-1][2*N_LOG2-1:N_LOG2];
  assign wb_addr_b   = dly_q[WB_LAT-1][N_LOG2-1:0];

endmodule

// File: tb/tb_fft_agu.sv
// Directed scoreboard bench for fft_agu: N=8 sequences with holds, reset abort, busy-start, and N=4.
module tb_fft_agu;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       start = 1'b0, hold = 1'b0;
  logic       busy, done, iv, wbv;
  logic [2:0] a, b, wba, wbb;
  logic [1:0] tw;
  logic [3:0] stg;

  logic       start4 = 1'b0, hold4 = 1'b0;
  logic       busy4, done4, iv4, wbv4;
  logic [1:0] a4, b4, wba4, wbb4;
  logic [0:0] tw4;
  logic [3:0] stg4;

  fft_agu #(.N_LOG2(3), .FLUSH_CYC(3), .WB_LAT(3)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .hold(hold),
    .busy(busy), .done(done), .issue_valid(iv), .addr_a(a), .addr_b(b),
    .tw_addr(tw), .stage(stg), .wb_valid(wbv), .wb_addr_a(wba), .wb_addr_b(wbb)
  );

  fft_agu #(.N_LOG2(2), .FLUSH_CYC(3), .WB_LAT(3)) dut4 (
    .clk(clk), .reset_n(reset_n), .start(start4), .hold(hold4),
    .busy(busy4), .done(done4), .issue_valid(iv4), .addr_a(a4), .addr_b(b4),
    .tw_addr(tw4), .stage(stg4), .wb_valid(wbv4), .wb_addr_a(wba4), .wb_addr_b(wbb4)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] tup;
    int          n;
  } exp_t;

  int   errors = 0;
  int   checks = 0;
  int   cyc_rel = 0;
  int   exp_done = 22;
  int   done_cnt = 0;
  exp_t iq[$];
  exp_t wq[$];

  int exp_a  [12] = '{0, 2, 4, 6, 0, 1, 4, 5, 0, 1, 2, 3};
  int exp_b  [12] = '{1, 3, 5, 7, 2, 3, 6, 7, 4, 5, 6, 7};
  int exp_tw [12] = '{0, 0, 0, 0, 0, 2, 0, 2, 0, 1, 2, 3};

  int a4_t  [4] = '{0, 2, 0, 1};
  int b4_t  [4] = '{1, 3, 2, 3};
  int tw4_t [4] = '{0, 0, 0, 1};
  int st4_t [4] = '{0, 0, 1, 1};
  int n4_t  [4] = '{1, 2, 6, 7};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic tick_raw();
    @(posedge clk);
    #1;
  endtask

  // Expected issue/writeback stream; issues at index >= sh_from are late by sh cycles
  task automatic load(input int sh_from, input int sh);
    exp_t e;
    iq.delete();
    wq.delete();
    for (int i = 0; i < 12; i++) begin
      e.n   = 1 + 7 * (i / 4) + (i % 4) + ((i >= sh_from) ? sh : 0);
      e.tup = (exp_a[i] << 9) | (exp_b[i] << 6) | (exp_tw[i] << 4) | (i / 4);
      iq.push_back(e);
      e.tup = (exp_a[i] << 3) | exp_b[i];
      e.n   = e.n + 3;
      wq.push_back(e);
    end
    exp_done = 22 + sh;
    done_cnt = 0;
  endtask

  task automatic mon();
    exp_t e;
    cyc_rel++;
    chk("busy", {31'd0, busy}, {31'd0, (cyc_rel >= 0 && cyc_rel < exp_done)});
    if (iv) begin
      if (iq.size() == 0) begin
        chk("issue_extra", 32'd1, 32'd0);
      end else begin
        e = iq.pop_front();
        chk("issue_tuple", {20'd0, a, b, tw, stg}, e.tup);
        chk("issue_cycle", cyc_rel, e.n);
      end
    end
    if (wbv) begin
      if (wq.size() == 0) begin
        chk("wb_extra", 32'd1, 32'd0);
      end else begin
        e = wq.pop_front();
        chk("wb_tuple", {26'd0, wba, wbb}, e.tup);
        chk("wb_cycle", cyc_rel, e.n);
      end
    end
    if (done) begin
      done_cnt++;
      chk("done_cycle", cyc_rel, exp_done);
    end
  endtask

  // One full transform; hold is driven on edges hlo..hhi, extra start pulses on edges p1/p2
  task automatic run_xfer(input int hlo, input int hhi, input int sh_from, input int sh,
                          input int p1, input int p2);
    int e;
    load(sh_from, sh);
    cyc_rel = -1;
    for (int t = 0; t < 30; t++) begin
      e     = cyc_rel + 1;
      start = (e == 0 || e == p1 || e == p2);
      hold  = (e >= hlo && e <= hhi);
      tick_raw();
      mon();
    end
    start = 1'b0;
    hold  = 1'b0;
    chk("issues_left", iq.size(), 32'd0);
    chk("wb_left", wq.size(), 32'd0);
    chk("done_count", done_cnt, 32'd1);
  endtask

  task automatic chk_zero(input string tag);
    chk(tag, {10'd0, busy, done, iv, a, b, tw, stg, wbv, wba, wbb}, 32'd0);
  endtask

  initial begin
    int idx4, d4, r4;

    // Reset state
    tick_raw();
    tick_raw();
    chk_zero("reset_state");
    chk("reset_state4", {16'd0, busy4, done4, iv4, a4, b4, tw4, stg4, wbv4, wba4, wbb4}, 32'd0);
    reset_n = 1'b1;
    tick_raw();

    // Plain transform, with start pulses while busy at edges 5 and 21
    run_xfer(-5, -6, 99, 0, 5, 21);
    // Hold two edges after stage0 k=1 issued
    run_xfer(3, 4, 2, 2, -9, -9);
    // Hold on the last butterfly of stage 0
    run_xfer(4, 4, 3, 1, -9, -9);
    // start and hold together in IDLE, hold continuing into RUN
    run_xfer(0, 1, 0, 1, -9, -9);

    // Reset in the middle of a transform
    load(99, 0);
    cyc_rel = -1;
    start = 1'b1;
    tick_raw();
    mon();
    start = 1'b0;
    for (int t = 0; t < 9; t++) begin
      tick_raw();
      mon();
    end
    reset_n = 1'b0;
    #1;
    chk_zero("async_reset");
    for (int t = 0; t < 3; t++) begin
      tick_raw();
      chk_zero("in_reset");
    end
    #1;
    reset_n = 1'b1;
    tick_raw();
    chk_zero("after_reset");
    run_xfer(-5, -6, 99, 0, -9, -9);

    // Smallest size: N=4
    idx4 = 0;
    d4 = 0;
    r4 = 0;
    start4 = 1'b1;
    tick_raw();
    start4 = 1'b0;
    for (int t = 0; t < 20; t++) begin
      tick_raw();
      r4++;
      if (iv4) begin
        if (idx4 < 4) begin
          chk("n4_tuple", {23'd0, a4, b4, tw4, stg4},
              (a4_t[idx4] << 7) | (b4_t[idx4] << 5) | (tw4_t[idx4] << 4) | st4_t[idx4]);
          chk("n4_cycle", r4, n4_t[idx4]);
        end
        idx4++;
      end
      if (done4) begin
        d4++;
        chk("n4_done_cycle", r4, 32'd11);
      end
    end
    chk("n4_issue_count", idx4, 32'd4);
    chk("n4_done_count", d4, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
